gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises the three-output gate unit (y[2]=a&b, y[1]=a|b, y[0]=~a) in hardware. On a start request it drives all four {a,b} combinations into the unit, lets each settle for a programmable number of cycles, and samples and checks y against the expected truth table. It then reports pass/fail and an error count. It sits between a host or self-test trigger and the gate unit, and owns the gate unit's inputs for the whole sweep.

---
 rtl/gate_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Drives all four {a,b} vectors into the gate unit, checks y against the truth table and reports pass/err_count.
// Define GATE_SWEEP_ERRLOG_EN to add fail_vec_o/fail_y_o capture of the first failing vector.
module gate_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [2:0] y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
`ifdef GATE_SWEEP_ERRLOG_EN
    output logic [1:0] fail_vec_o,
    output logic [2:0] fail_y_o,
`endif
    output logic [2:0] err_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic [2:0] expected;
    logic       mismatch;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [2:0] fail_y_q, fail_y_d;
`endif

    assign expected = {a_q & b_q, a_q | b_q, ~a_q};
    assign mismatch = (y_i != expected);

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        pass_d  = pass_q;
`ifdef GATE_SWEEP_ERRLOG_EN
        fail_vec_d = fail_vec_q;
        fail_y_d   = fail_y_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start_i) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
`ifdef GATE_SWEEP_ERRLOG_EN
                    fail_vec_d = 2'd0;
                    fail_y_d   = 3'd0;
`endif
                end
            end
            S_DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 3'd1;
`ifdef GATE_SWEEP_ERRLOG_EN
                    if (err_q == 3'd0) begin
                        fail_vec_d = {a_q, b_q};
                        fail_y_d   = y_i;
                    end
`endif
                end
                // The next vector is loaded on the same edge that leaves SAMPLE so it gets the full hold window.
                if (vec_q == 2'd3) begin
                    state_d = S_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_q + 2'd1;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
`ifdef GATE_SWEEP_ERRLOG_EN
            fail_vec_q <= 2'd0;
            fail_y_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
`ifdef GATE_SWEEP_ERRLOG_EN
            fail_vec_q <= fail_vec_d;
            fail_y_q   <= fail_y_d;
`endif
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign busy_o      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
`ifdef GATE_SWEEP_ERRLOG_EN
    assign fail_vec_o  = fail_vec_q;
    assign fail_y_o    = fail_y_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench: two controller instances (HOLD_CYCLES 4 and 1) driving a behavioural gate unit with injectable faults.
module tb_gate_sweep_ctrl;

    typedef struct {
        logic [2:0] err;
        logic       pass;
        logic [1:0] fvec;
        logic [2:0] fy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start4 = 1'b0;
    logic start1 = 1'b0;
    int   fault_sel = 0;
    bit   sel1 = 1'b0;

    logic [2:0] y4, y1, err4, err1;
    logic       a4, b4, busy4, done4, pass4;
    logic       a1, b1, busy1, done1, pass1;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic [1:0] fv4, fv1;
    logic [2:0] fy4, fy1;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [2:0] gate_model(input logic a, input logic b, input int f);
        logic [2:0] y;
        y = {a & b, a | b, ~a};
        if (f == 1) y[2] = 1'b0;
        if (f == 2) y[0] = 1'b0;
        return y;
    endfunction

    assign y4 = gate_model(a4, b4, fault_sel);
    assign y1 = gate_model(a1, b1, fault_sel);

    gate_sweep_ctrl #(.HOLD_CYCLES(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .y_i(y4),
        .a_o(a4), .b_o(b4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
`ifdef GATE_SWEEP_ERRLOG_EN
        .fail_vec_o(fv4), .fail_y_o(fy4),
`endif
        .err_count_o(err4)
    );

    gate_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .y_i(y1),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
`ifdef GATE_SWEEP_ERRLOG_EN
        .fail_vec_o(fv1), .fail_y_o(fy1),
`endif
        .err_count_o(err1)
    );

    logic [1:0] mon_ab;
    logic       mon_busy, mon_done, mon_pass;
    logic [2:0] mon_err;
`ifdef GATE_SWEEP_ERRLOG_EN
    logic [1:0] mon_fv;
    logic [2:0] mon_fy;
`endif

    always_comb begin
        mon_ab   = sel1 ? {a1, b1} : {a4, b4};
        mon_busy = sel1 ? busy1 : busy4;
        mon_done = sel1 ? done1 : done4;
        mon_pass = sel1 ? pass1 : pass4;
        mon_err  = sel1 ? err1 : err4;
`ifdef GATE_SWEEP_ERRLOG_EN
        mon_fv   = sel1 ? fv1 : fv4;
        mon_fy   = sel1 ? fy1 : fy4;
`endif
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel1) start1 = v;
        else      start4 = v;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ab"},   8'(mon_ab),   8'd0);
        check({tag, "_busy"}, 8'(mon_busy), 8'd0);
        check({tag, "_done"}, 8'(mon_done), 8'd0);
    endtask

    // Runs one sweep on the selected instance; spam keeps start high through the whole sweep and the DONE edge.
    task automatic run_sweep(input bit use1, input int fault, input bit spam);
        int   h;
        int   len;
        exp_t e;
        exp_t got;
        logic [2:0] ym;
        sel1      = use1;
        fault_sel = fault;
        h   = use1 ? 1 : 4;
        len = 4 * (h + 1);
        e.err = 3'd0; e.fvec = 2'd0; e.fy = 3'd0;
        for (int v = 0; v < 4; v++) begin
            ym = gate_model(v[1], v[0], fault);
            if (ym != {v[1] & v[0], v[1] | v[0], ~v[1]}) begin
                if (e.err == 3'd0) begin
                    e.fvec = v[1:0];
                    e.fy   = ym;
                end
                e.err = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 3'd0);
        exp_q.push_back(e);

        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            if (n == 1 && !spam) set_start(1'b0);
            check($sformatf("busy_c%0d", n), 8'(mon_busy), 8'd1);
            check($sformatf("done_c%0d", n), 8'(mon_done), 8'd0);
            check($sformatf("ab_c%0d", n),   8'(mon_ab),   8'((n - 1) / (h + 1)));
        end
        @(negedge clk);
        got = exp_q.pop_front();
        check("done_pulse", 8'(mon_done), 8'd1);
        check("done_busy",  8'(mon_busy), 8'd0);
        check("done_ab",    8'(mon_ab),   8'd0);
        check("err_count",  8'(mon_err),  8'(got.err));
        check("pass",       8'(mon_pass), 8'(got.pass));
`ifdef GATE_SWEEP_ERRLOG_EN
        check("fail_vec",   8'(mon_fv),   8'(got.fvec));
        check("fail_y",     8'(mon_fy),   8'(got.fy));
`endif
        @(negedge clk);
        set_start(1'b0);
        check_idle_outputs("post_done");
        check("pass_held",  8'(mon_pass), 8'(got.pass));
        @(negedge clk);
        check("post_done2_busy", 8'(mon_busy), 8'd0);
        sel1 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sel1 = 1'b0;
        check_idle_outputs("rst4");
        check("rst4_pass", 8'(pass4), 8'd0);
        check("rst4_err",  8'(err4),  8'd0);
        sel1 = 1'b1;
        check_idle_outputs("rst1");
        sel1 = 1'b0;

        run_sweep(1'b0, 0, 1'b0);
        run_sweep(1'b0, 1, 1'b0);
        run_sweep(1'b0, 2, 1'b0);
        run_sweep(1'b0, 0, 1'b1);

        // Abort during vector 10 with a one-cycle reset pulse.
        fault_sel = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        check("abort_ab_before", 8'({a4, b4}), 8'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("abort");
        check("abort_pass", 8'(pass4), 8'd0);
        check("abort_err",  8'(err4),  8'd0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check($sformatf("abort_nodone_%0d", n), 8'(done4), 8'd0);
            check($sformatf("abort_idle_%0d", n),   8'(busy4), 8'd0);
        end
        run_sweep(1'b0, 0, 1'b0);

        run_sweep(1'b1, 0, 1'b0);
        run_sweep(1'b1, 2, 1'b0);

        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
